encoder_8_to_3_serial: RTL and testbench

Sequential counterpart to the 3-to-8 decoder. It captures an 8-bit request word on an enable strobe and emits the binary index of every set bit, one index per handshake. Indices leave highest bit first, on a valid/ready stream. It is used to turn multi-hot event/request vectors back into 3-bit codes for downstream logic that accepts one code at a time.

---
 rtl/encoder_8_to_3_serial.sv | 131 +++++++++++++
 tb/tb_encoder_8_to_3_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8_to_3_serial.sv
// Serial priority encoder: captures a multi-hot request word and streams the
// index of each set bit, highest first, over a valid/ready handshake.
module encoder_8_to_3_serial #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         e,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         last,
  output logic         z
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q,  pend_d;
  logic [W-1:0] y_q,     y_d;
  logic         valid_q, valid_d;
  logic         last_q,  last_d;
  logic         z_q,     z_d;

  logic [N-1:0] src;
  logic [W-1:0] src_idx;
  logic [N-1:0] src_rest;
  logic         src_single;

  // Priority encoder: later (higher) bits overwrite lower ones.
  function automatic logic [W-1:0] msb_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // The word being peeled this cycle: the fresh request in IDLE, the remainder in SCAN.
  always_comb begin
    src        = (state_q == IDLE) ? d : pend_q;
    src_idx    = msb_idx(src);
    src_rest   = src & ~(N'(1) << src_idx);
    src_single = is_single(src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (e && (d != '0)) state_d = SCAN;
      SCAN:    if (ready && (pend_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    y_d     = y_q;
    valid_d = valid_q;
    last_d  = last_q;
    z_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (e) begin
          if (d != '0) begin
            pend_d  = src_rest;
            y_d     = src_idx;
            valid_d = 1'b1;
            last_d  = src_single;
          end else begin
            z_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (ready) begin
          if (pend_q != '0) begin
            pend_d = src_rest;
            y_d    = src_idx;
            last_d = src_single;
          end else begin
            pend_d  = '0;
            y_d     = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        pend_d  = '0;
        y_d     = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign z     = z_q;

endmodule

// File: tb/tb_encoder_8_to_3_serial.sv
// Directed bench for encoder_8_to_3_serial; expected indices are queued at
// load time and consumed on each handshake.
module tb_encoder_8_to_3_serial;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       e;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic       last;
  logic       z;

  typedef struct packed {
    logic [2:0] y;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_hs;

  encoder_8_to_3_serial #(.N(8), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .e     (e),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .last  (last),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: every set bit of the word, highest first.
  task automatic push_word(input logic [7:0] dv);
    exp_t       it;
    logic [7:0] below;
    for (int i = 7; i >= 0; i--) begin
      if (dv[i]) begin
        below   = (8'(1) << i) - 8'd1;
        it.y    = 3'(i);
        it.last = ((dv & below) == 8'd0);
        exp_q.push_back(it);
      end
    end
  endtask

  // Score any handshake about to happen, then advance one clock.
  task automatic clk_step();
    exp_t it;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(y), 32'hFFFF_FFFF);
      end else begin
        it = exp_q.pop_front();
        chk("y", 32'(y), 32'(it.y));
        chk("last", 32'(last), 32'(it.last));
      end
    end else if (!valid) begin
      chk("idle_y", 32'(y), 32'd0);
      chk("idle_last", 32'(last), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] dv, input bit keep_e);
    d = dv;
    e = 1'b1;
    if (dv != 8'd0) push_word(dv);
    clk_step();
    if (!keep_e) e = 1'b0;
    chk("load_valid", 32'(valid), 32'(dv != 8'd0));
    chk("load_z", 32'(z), 32'(dv == 8'd0));
  endtask

  task automatic drain(input bit toggle, output int n);
    logic [2:0] yp;
    logic       lp;
    logic       rd;
    n = 0;
    for (int k = 0; k < 64 && valid; k++) begin
      if (toggle) ready = (k % 2 == 0);
      yp = y;
      lp = last;
      rd = ready;
      clk_step();
      if (rd) n++;
      else begin
        chk("hold_y", 32'(y), 32'(yp));
        chk("hold_last", 32'(last), 32'(lp));
        chk("hold_valid", 32'(valid), 32'd1);
      end
    end
    chk("drain_valid", 32'(valid), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset held with an active load attempt.
    rst_n = 1'b0;
    e     = 1'b1;
    d     = 8'hFF;
    ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_z", 32'(z), 32'd0);
    end
    e     = 1'b0;
    rst_n = 1'b1;
    clk_step();

    // Asynchronous reset in the middle of a scan.
    ready = 1'b0;
    load(8'hFF, 1'b0);
    clk_step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_last", 32'(last), 32'd0);
    chk("arst_z", 32'(z), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_arst_valid", 32'(valid), 32'd0);

    // Single bit.
    ready = 1'b1;
    load(8'b0000_1000, 1'b0);
    drain(1'b0, n_hs);
    chk("single_hs", 32'(n_hs), 32'd1);

    // Multi-hot streaming, one index per cycle.
    load(8'b1010_0101, 1'b0);
    drain(1'b0, n_hs);
    chk("multi_hs", 32'(n_hs), 32'd4);

    // Backpressure.
    ready = 1'b0;
    load(8'b0000_0011, 1'b0);
    repeat (3) begin
      clk_step();
      chk("bp_y", 32'(y), 32'd1);
      chk("bp_last", 32'(last), 32'd0);
      chk("bp_valid", 32'(valid), 32'd1);
    end
    ready = 1'b1;
    drain(1'b0, n_hs);
    chk("bp_hs", 32'(n_hs), 32'd2);

    // Zero load pulses z for one cycle only.
    load(8'h00, 1'b0);
    clk_step();
    chk("z_pulse_end", 32'(z), 32'd0);
    chk("z_no_valid", 32'(valid), 32'd0);

    // Loads ignored during scan, including the final handshake edge.
    load(8'h81, 1'b0);
    d = 8'hFF;
    e = 1'b1;
    drain(1'b0, n_hs);
    chk("ignore_hs", 32'(n_hs), 32'd2);
    chk("ignore_z", 32'(z), 32'd0);
    // e still high on the first idle cycle: accepted.
    load(8'hFF, 1'b0);
    drain(1'b0, n_hs);
    chk("reload_hs", 32'(n_hs), 32'd8);

    // Full word with toggling ready.
    load(8'hFF, 1'b0);
    drain(1'b1, n_hs);
    chk("full_hs", 32'(n_hs), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
